// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding and
// the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard sequencer.
// The slave side is the sequencer; the master side is the surrounding core.
interface pipe_hazard_ctrl_if #(
  parameter int STALL_W = 32
);

  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic [4:0]         ex_rd;
  logic               ex_rf_nwe;
  logic               ex_is_ram;
  logic               ex_branch_taken;
  logic               md_req;

  logic               pc_stall;
  logic               if_id_stall;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic               md_busy;
  logic               md_done;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_rf_nwe,
           ex_is_ram, ex_branch_taken, md_req,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy,
           md_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_rf_nwe,
           ex_is_ram, ex_branch_taken, md_req,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy,
           md_done, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Purely combinational.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_rf_nwe_i,
  input  logic       ex_is_ram_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);

  // $zero is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use_o = ex_is_ram_i && ex_rf_nwe_i && (ex_rd_i != REG_ZERO)
                      && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID stall, IF-ID flush and ID-EX bubble from
// taken branches, MUL/DIV occupancy and load-use hazards; saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int MD_CNT_W  = 6,
  parameter int STALL_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  pipe_state_e         state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy, md_done;

  load_use_detect u_load_use (
    .id_rs_i      (hz.id_rs),
    .id_rt_i      (hz.id_rt),
    .id_uses_rs_i (hz.id_uses_rs),
    .id_uses_rt_i (hz.id_uses_rt),
    .ex_rd_i      (hz.ex_rd),
    .ex_rf_nwe_i  (hz.ex_rf_nwe),
    .ex_is_ram_i  (hz.ex_is_ram),
    .load_use_o   (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;

    if (!reset) begin
      unique case (state_q)
        RUN: begin
          // A taken branch squashes the ID instruction, so its md_req/load_use are moot.
          if (hz.ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hz.md_req) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = MD_WAIT;
            md_cnt_d     = MD_CNT_W'(MD_CYCLES - 1);
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          if (md_cnt_q != '0) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            md_cnt_d     = md_cnt_q - MD_CNT_W'(1);
          end else begin
            // Release cycle: the MUL/DIV advances, and its still-high md_req must not restart it.
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + STALL_W'(1)
                                                     : stall_cnt_q;

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.md_busy      = md_busy;
  assign hz.md_done      = md_done;
  assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int MD_CYCLES = 4;
  localparam int MD_CNT_W  = 6;
  localparam int STALL_W   = 3;
  localparam int SAT       = (1 << STALL_W) - 1;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.STALL_W(STALL_W)) pif ();

  pipe_hazard_ctrl #(
    .MD_CYCLES (MD_CYCLES),
    .MD_CNT_W  (MD_CNT_W),
    .STALL_W   (STALL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles left in the MUL/DIV occupancy window (0 = idle) and stall count.
  int busy_left = 0;
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pif.id_rs = 5'd0;  pif.id_rt = 5'd0;
    pif.id_uses_rs = 1'b0; pif.id_uses_rt = 1'b0;
    pif.ex_rd = 5'd0;  pif.ex_rf_nwe = 1'b0; pif.ex_is_ram = 1'b0;
    pif.ex_branch_taken = 1'b0; pif.md_req = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    pif.ex_is_ram = 1'b1; pif.ex_rf_nwe = 1'b1; pif.ex_rd = rd;
  endtask

  task automatic assert_reset_now();
    reset = 1'b1;
    busy_left = 0;
    model_cnt = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cyc(input string tag);
    logic lu, e_stall, e_flush, e_bubble, e_busy, e_done, start;
    @(negedge clk);
    lu = pif.ex_is_ram && pif.ex_rf_nwe && (pif.ex_rd != 5'd0) &&
         ((pif.id_uses_rs && pif.id_rs == pif.ex_rd) ||
          (pif.id_uses_rt && pif.id_rt == pif.ex_rd));
    e_stall = 0; e_flush = 0; e_bubble = 0; e_busy = 0; e_done = 0; start = 0;
    if (reset) begin
      // everything stays low
    end else if (busy_left > 0) begin
      e_busy = 1;
      if (busy_left > 1) begin e_stall = 1; e_bubble = 1; end
      else e_done = 1;
    end else if (pif.ex_branch_taken) begin
      e_flush = 1; e_bubble = 1;
    end else if (pif.md_req) begin
      e_stall = 1; e_bubble = 1; start = 1;
    end else if (lu) begin
      e_stall = 1; e_bubble = 1;
    end
    chk({tag, ".pc_stall"},     32'(pif.pc_stall),     32'(e_stall));
    chk({tag, ".if_id_stall"},  32'(pif.if_id_stall),  32'(e_stall));
    chk({tag, ".if_id_flush"},  32'(pif.if_id_flush),  32'(e_flush));
    chk({tag, ".id_ex_bubble"}, 32'(pif.id_ex_bubble), 32'(e_bubble));
    chk({tag, ".md_busy"},      32'(pif.md_busy),      32'(e_busy));
    chk({tag, ".md_done"},      32'(pif.md_done),      32'(e_done));
    chk({tag, ".stall_cnt"},    32'(pif.stall_cnt),    32'(model_cnt));
    @(posedge clk);
    if (reset) begin
      busy_left = 0;
      model_cnt = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      else if (start) busy_left = MD_CYCLES;
      if (e_stall && model_cnt < SAT) model_cnt++;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    assert_reset_now();
    @(posedge clk); #1;
    cyc("reset");
    reset = 1'b0;
    cyc("idle");

    // Load-use on rs, then the same with $zero as the load destination.
    set_load(5'd8); pif.id_rs = 5'd8; pif.id_uses_rs = 1'b1;
    cyc("lu_rs");
    chk("lu_rs_cnt", 32'(pif.stall_cnt), 32'd1);
    pif.ex_rd = 5'd0;
    cyc("lu_zero");
    chk("lu_zero_cnt", 32'(pif.stall_cnt), 32'd1);

    // rt match only counts when rt is actually read.
    clear_inputs();
    set_load(5'd5); pif.id_rt = 5'd5;
    cyc("rt_unused");
    pif.id_uses_rt = 1'b1;
    cyc("rt_used");
    clear_inputs();
    cyc("rt_after");

    // MUL/DIV with md_req held through the done cycle.
    assert_reset_now(); #1; reset = 1'b0;
    pif.md_req = 1'b1;
    for (int i = 0; i < MD_CYCLES + 1; i++) cyc($sformatf("md_T%0d", i));
    chk("md_done_cnt", 32'(pif.stall_cnt), 32'(MD_CYCLES));
    pif.md_req = 1'b0;
    cyc("md_after");

    // Branch outranks both md_req and load-use.
    set_load(5'd3); pif.id_rs = 5'd3; pif.id_uses_rs = 1'b1;
    pif.md_req = 1'b1; pif.ex_branch_taken = 1'b1;
    cyc("branch");
    clear_inputs();
    cyc("branch_after");

    // Asynchronous reset in the middle of a MUL/DIV.
    pif.md_req = 1'b1;
    cyc("mdr_T0");
    cyc("mdr_T1");
    #2;
    pif.md_req = 1'b0;
    assert_reset_now();
    #1;
    chk("arst.md_busy",   32'(pif.md_busy),   32'd0);
    chk("arst.pc_stall",  32'(pif.pc_stall),  32'd0);
    chk("arst.id_ex_bubble", 32'(pif.id_ex_bubble), 32'd0);
    chk("arst.stall_cnt", 32'(pif.stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    cyc("arst_after");

    // Saturation of the stall counter over 9 separated hazards.
    for (int i = 0; i < 9; i++) begin
      set_load(5'd9); pif.id_rt = 5'd9; pif.id_uses_rt = 1'b1;
      cyc($sformatf("sat_lu%0d", i));
      clear_inputs();
      cyc($sformatf("sat_gap%0d", i));
    end
    chk("sat_cnt", 32'(pif.stall_cnt), 32'(SAT));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      pif.id_rs = 5'($urandom_range(0, 3));
      pif.id_rt = 5'($urandom_range(0, 3));
      pif.ex_rd = 5'($urandom_range(0, 3));
      pif.id_uses_rs = 1'($urandom_range(0, 1));
      pif.id_uses_rt = 1'($urandom_range(0, 1));
      pif.ex_is_ram  = 1'($urandom_range(0, 1));
      pif.ex_rf_nwe  = ($urandom_range(0, 3) != 0);
      pif.ex_branch_taken = ($urandom_range(0, 9) == 0);
      pif.md_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0) assert_reset_now();
      else reset = 1'b0;
      cyc($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
